// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared types and sizing helpers for the packet round-robin arbiter
//
// Holds the arbiter state type, the reset value of the last-grant index
// and the width helpers used by the top level and by rr_pick.
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_e;

  // last_grant resets to the highest index so that source 0 wins the first arbitration.
  function automatic int last_grant_rst(input int num_src);
    return num_src - 1;
  endfunction

  // Stall counter must be able to hold WDOG_CYC itself.
  function automatic int wdog_cnt_w(input int wdog_cyc);
    return $clog2(wdog_cyc + 1);
  endfunction

  // Width of a source index; never zero, even for a single source.
  function automatic int idx_w(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Purpose: choose the first requesting source starting one past last_idx,
// wrapping around. Purely combinational.
// Ports:
//   req       in   NUM_SRC  request vector
//   last_idx  in   IDX_W    index of the previously granted source
//   pick      out  NUM_SRC  one-hot chosen source (zero if no request)
//   pick_idx  out  IDX_W    index of the chosen source (zero if no request)
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int IDX_W   = idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_SRC-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx
);

  always_comb begin
    int  cand;
    logic found;
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = 0;
    // k runs 1..NUM_SRC so the last granted source is checked last.
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = (int'(last_idx) + k) % NUM_SRC;
      if (!found && req[cand]) begin
        found       = 1'b1;
        pick[cand]  = 1'b1;
        pick_idx    = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - packet-aware round-robin AXI-Stream arbiter
//
// Purpose: share one stream master port among NUM_SRC stream sources. A
// source keeps the grant for a whole packet (until its last beat is
// accepted); one IDLE cycle separates packets. Data/valid/last/ready are
// steered combinationally; only state and grant are registered.
// Optional feature macro: AXIS_ARB_WDOG_EN enables a stall watchdog that
// forcibly releases a grant after WDOG_CYC cycles with no transfer.
// Ports:
//   clk       in   1               clock, rising edge
//   reset     in   1               synchronous, active-high
//   s_data    in   NUM_SRC*DATA_W  source i at [i*DATA_W +: DATA_W]
//   s_valid   in   NUM_SRC         per-source valid
//   s_last    in   NUM_SRC         per-source end of packet
//   s_ready   out  NUM_SRC         per-source ready
//   m_data    out  DATA_W          output data
//   m_valid   out  1               output valid
//   m_last    out  1               output end of packet
//   m_ready   in   1               downstream ready
//   grant     out  NUM_SRC         one-hot owner, zero when idle
//   wdog_err  out  1               one-cycle pulse on forced release
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int DATA_W   = 8,
  parameter int WDOG_CYC = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC*DATA_W-1:0]   s_data,
  input  logic [NUM_SRC-1:0]          s_valid,
  input  logic [NUM_SRC-1:0]          s_last,
  output logic [NUM_SRC-1:0]          s_ready,
  output logic [DATA_W-1:0]           m_data,
  output logic                        m_valid,
  output logic                        m_last,
  input  logic                        m_ready,
  output logic [NUM_SRC-1:0]          grant,
  output logic                        wdog_err
);

  localparam int IDX_W = idx_w(NUM_SRC);

  arb_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NUM_SRC-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               pass_act;
  logic               xfer;
  logic               wdog_fire;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req      (s_valid),
    .last_idx (last_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // Outputs are forced quiet while reset is held, even if a packet was in flight.
  assign pass_act = (state_q == PASS) && !reset;
  assign grant    = pass_act ? grant_q : '0;

  always_comb begin
    m_data  = '0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    s_ready = '0;
    if (pass_act) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (gidx_q == IDX_W'(i)) begin
          m_data = s_data[i*DATA_W +: DATA_W];
        end
      end
      m_valid = s_valid[gidx_q];
      m_last  = s_last[gidx_q];
      s_ready = grant_q & {NUM_SRC{m_ready}};
    end
  end

  assign xfer = m_valid && m_ready;

`ifdef AXIS_ARB_WDOG_EN
  localparam int WDOG_W = wdog_cnt_w(WDOG_CYC);

  logic [WDOG_W-1:0] stall_q, stall_d;

  // Fires on the WDOG_CYC-th consecutive cycle without a transfer.
  assign wdog_fire = pass_act && !xfer && (stall_q == WDOG_W'(WDOG_CYC - 1));

  always_comb begin
    stall_d = stall_q;
    if ((state_q != PASS) || xfer || wdog_fire) begin
      stall_d = '0;
    end else begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  localparam int unused_wdog_cyc = WDOG_CYC;

  assign wdog_fire = 1'b0;
`endif

  assign wdog_err = wdog_fire;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|s_valid) begin
          state_d = PASS;
          grant_d = pick;
          gidx_d  = pick_idx;
        end
      end
      PASS: begin
        if ((xfer && m_last) || wdog_fire) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(last_grant_rst(NUM_SRC));
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb/tb_axis_rr_arbiter.sv - self-checking bench for axis_rr_arbiter (NUM_SRC=2, DATA_W=8)
module tb_axis_rr_arbiter;

  localparam logic [7:0] D0 = 8'h23;
  localparam logic [7:0] D1 = 8'h45;

  logic        clk;
  logic        reset;
  logic [15:0] s_data;
  logic [1:0]  s_valid;
  logic [1:0]  s_last;
  logic [1:0]  s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic [1:0]  grant;
  logic        wdog_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rst;
    logic [1:0] sv;
    logic [1:0] sl;
    logic       mr;
    logic [1:0] eg;
    logic       emv;
    logic [7:0] emd;
    logic       eml;
    logic [1:0] esr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  vec_t  tbl[$];
  beat_t sb[$];

  axis_rr_arbiter #(
    .NUM_SRC  (2),
    .DATA_W   (8),
    .WDOG_CYC (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .grant    (grant),
    .wdog_err (wdog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [1:0] sv, input logic [1:0] sl, input logic mr,
                     input logic [1:0] eg, input logic emv, input logic [7:0] emd,
                     input logic eml, input logic [1:0] esr);
    vec_t v;
    v.rst = rst; v.sv = sv; v.sl = sl; v.mr = mr;
    v.eg = eg; v.emv = emv; v.emd = emd; v.eml = eml; v.esr = esr;
    tbl.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted output beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got beat %0h with no expected beat", m_data);
      end else begin
        beat_t b;
        b = sb.pop_front();
        chk("sb_data", {24'd0, m_data}, {24'd0, b.data});
        chk("sb_last", {31'd0, m_last}, {31'd0, b.last});
      end
    end
  end

  initial begin
    bit seen;
    reset   = 1'b1;
    s_data  = {D1, D0};
    s_valid = 2'b00;
    s_last  = 2'b00;
    m_ready = 1'b1;

    //   rst sv     sl     mr    eg     mv    md    ml    sr
    // reset with both valid, then first arbitration -> source 0
    add(1, 2'b11, 2'b11, 1, 2'b00, 0, 8'h00, 0, 2'b00);
    add(1, 2'b11, 2'b11, 1, 2'b00, 0, 8'h00, 0, 2'b00);
    add(0, 2'b11, 2'b11, 1, 2'b00, 0, 8'h00, 0, 2'b00);
    add(0, 2'b11, 2'b11, 1, 2'b01, 1, D0,    1, 2'b01);
    add(0, 2'b00, 2'b00, 1, 2'b00, 0, 8'h00, 0, 2'b00);
    // source 0 alone, 3-beat packet
    add(0, 2'b01, 2'b00, 1, 2'b00, 0, 8'h00, 0, 2'b00);
    add(0, 2'b01, 2'b00, 1, 2'b01, 1, D0,    0, 2'b01);
    add(0, 2'b01, 2'b00, 1, 2'b01, 1, D0,    0, 2'b01);
    add(0, 2'b01, 2'b01, 1, 2'b01, 1, D0,    1, 2'b01);
    add(0, 2'b00, 2'b00, 1, 2'b00, 0, 8'h00, 0, 2'b00);
    // source 1 wins (round robin), drops valid for 2 cycles mid-packet
    add(0, 2'b11, 2'b00, 1, 2'b00, 0, 8'h00, 0, 2'b00);
    add(0, 2'b11, 2'b00, 1, 2'b10, 1, D1,    0, 2'b10);
    add(0, 2'b01, 2'b00, 1, 2'b10, 0, D1,    0, 2'b10);
    add(0, 2'b01, 2'b00, 1, 2'b10, 0, D1,    0, 2'b10);
    add(0, 2'b11, 2'b10, 1, 2'b10, 1, D1,    1, 2'b10);
    // both valid, 1-beat packets: alternate with a bubble between
    add(0, 2'b11, 2'b11, 1, 2'b00, 0, 8'h00, 0, 2'b00);
    add(0, 2'b11, 2'b11, 1, 2'b01, 1, D0,    1, 2'b01);
    add(0, 2'b11, 2'b11, 1, 2'b00, 0, 8'h00, 0, 2'b00);
    add(0, 2'b11, 2'b11, 1, 2'b10, 1, D1,    1, 2'b10);
    add(0, 2'b11, 2'b11, 1, 2'b00, 0, 8'h00, 0, 2'b00);
    add(0, 2'b11, 2'b11, 1, 2'b01, 1, D0,    1, 2'b01);
    add(0, 2'b11, 2'b11, 1, 2'b00, 0, 8'h00, 0, 2'b00);
    add(0, 2'b11, 2'b11, 1, 2'b10, 1, D1,    1, 2'b10);
    // source 0 backpressured 3 cycles while source 1 waits
    add(0, 2'b11, 2'b00, 1, 2'b00, 0, 8'h00, 0, 2'b00);
    add(0, 2'b11, 2'b00, 1, 2'b01, 1, D0,    0, 2'b01);
    add(0, 2'b11, 2'b00, 0, 2'b01, 1, D0,    0, 2'b00);
    add(0, 2'b11, 2'b00, 0, 2'b01, 1, D0,    0, 2'b00);
    add(0, 2'b11, 2'b00, 0, 2'b01, 1, D0,    0, 2'b00);
    add(0, 2'b11, 2'b01, 1, 2'b01, 1, D0,    1, 2'b01);
    add(0, 2'b10, 2'b10, 1, 2'b00, 0, 8'h00, 0, 2'b00);
    add(0, 2'b10, 2'b10, 1, 2'b10, 1, D1,    1, 2'b10);
    add(0, 2'b00, 2'b00, 1, 2'b00, 0, 8'h00, 0, 2'b00);
    // reset in the middle of a packet drops it
    add(0, 2'b01, 2'b00, 1, 2'b00, 0, 8'h00, 0, 2'b00);
    add(0, 2'b01, 2'b00, 1, 2'b01, 1, D0,    0, 2'b01);
    add(1, 2'b01, 2'b00, 1, 2'b00, 0, 8'h00, 0, 2'b00);
    add(0, 2'b11, 2'b00, 1, 2'b00, 0, 8'h00, 0, 2'b00);
    add(0, 2'b01, 2'b00, 1, 2'b01, 1, D0,    0, 2'b01);
    add(0, 2'b01, 2'b01, 1, 2'b01, 1, D0,    1, 2'b01);
    add(0, 2'b00, 2'b00, 1, 2'b00, 0, 8'h00, 0, 2'b00);

    next_cycle();
    for (int i = 0; i < tbl.size(); i++) begin
      reset   = tbl[i].rst;
      s_valid = tbl[i].sv;
      s_last  = tbl[i].sl;
      m_ready = tbl[i].mr;
      if (!tbl[i].rst && tbl[i].emv && tbl[i].mr) begin
        beat_t b;
        b.data = tbl[i].emd;
        b.last = tbl[i].eml;
        sb.push_back(b);
      end
      @(negedge clk);
      chk($sformatf("r%0d grant", i),   {30'd0, grant},    {30'd0, tbl[i].eg});
      chk($sformatf("r%0d m_valid", i), {31'd0, m_valid},  {31'd0, tbl[i].emv});
      chk($sformatf("r%0d m_data", i),  {24'd0, m_data},   {24'd0, tbl[i].emd});
      chk($sformatf("r%0d m_last", i),  {31'd0, m_last},   {31'd0, tbl[i].eml});
      chk($sformatf("r%0d s_ready", i), {30'd0, s_ready},  {30'd0, tbl[i].esr});
      chk($sformatf("r%0d wdog_err", i), {31'd0, wdog_err}, 32'd0);
      next_cycle();
    end

`ifdef AXIS_ARB_WDOG_EN
    // source 0 granted, then goes silent: forced release after 4 stall cycles
    s_valid = 2'b01; s_last = 2'b00; m_ready = 1'b1;
    @(negedge clk);
    chk("wd_idle_grant", {30'd0, grant}, 32'd0);
    next_cycle();
    s_valid = 2'b10; s_last = 2'b10;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("wd_stall%0d grant", k), {30'd0, grant}, 32'd1);
      chk($sformatf("wd_stall%0d err", k), {31'd0, wdog_err}, (k == 3) ? 32'd1 : 32'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("wd_release_grant", {30'd0, grant}, 32'd0);
    chk("wd_release_err", {31'd0, wdog_err}, 32'd0);
    next_cycle();
    begin
      beat_t b;
      b.data = D1; b.last = 1'b1;
      sb.push_back(b);
    end
    @(negedge clk);
    chk("wd_next_grant", {30'd0, grant}, 32'd2);
    chk("wd_next_data", {24'd0, m_data}, {24'd0, D1});
    next_cycle();
    s_valid = 2'b00; s_last = 2'b00;
    next_cycle();
`endif

    // bounded wait for a lone source-1 packet to be granted
    s_valid = 2'b10; s_last = 2'b10; m_ready = 1'b1;
    begin
      beat_t b;
      b.data = D1; b.last = 1'b1;
      sb.push_back(b);
    end
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(negedge clk);
      if (grant == 2'b10) seen = 1'b1;
      next_cycle();
    end
    chk("wait_grant_src1", {31'd0, seen}, 32'd1);
    s_valid = 2'b00; s_last = 2'b00;
    @(negedge clk);
    chk("final_idle_grant", {30'd0, grant}, 32'd0);
    next_cycle();
    next_cycle();
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
